slice_reassembler: RTL and testbench
====================================

// Module: slice_reassembler
// PURPOSE
//  Receive end of the wide-bus slicing scheme. A WIDTH-bit word is carried as NUM_SLICES narrow
//  beats of SLICE_W bits each, sent least-significant slice first. This block collects the beats
//  over a valid/ready link and presents the rebuilt WIDTH-bit word on a valid/ready output.
//  It sits at the destination of any narrow-lane transport that uses the same slice count rule.
// PARAMETERS
//  WIDTH      33  width of the reassembled word, in bits
//  MAX_WIDTH  11  upper bound on slice width (MAX_WIDTH >= 1)
//  NUM_SLICES derived, localparam = slice_pkg::num_slices(WIDTH, MAX_WIDTH), equal to 4 at defaults
//  SLICE_W    derived, localparam = ceil(WIDTH/NUM_SLICES), equal to 9 at defaults
// PORTS
//  clk        in   1        single clock; all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        slice beat valid
//  in_ready   out  1        slice beat accepted when in_valid && in_ready
//  in_first   in   1        marks slice 0 of a word
//  in_data    in   SLICE_W  slice payload
//  out_valid  out  1        reassembled word valid
//  out_ready  in   1        word consumed when out_valid && out_ready
//  out_data   out  WIDTH    reassembled word
//  err_resync out  1        one-cycle pulse: a partial word was dropped
// BEHAVIOUR
//  - Reset values (rst sampled high at a clk edge): out_valid=0, err_resync=0, out_data='0, slice index=0,
//    state=COLLECT. rst during any operation discards any partial word and any held word.
//  - States: COLLECT (index 0..NUM_SLICES-1) and HOLD (full word presented).
//  - in_ready = (state==COLLECT) || (out_valid && out_ready). This gives pass-through accept when the
//    held word drains in the same cycle. in_ready is combinational from out_ready.
//  - An accepted beat writes in_data into bits [i*SLICE_W +: SLICE_W] of the assembly register,
//    where i is the slice index. On the last slice, bits at position WIDTH and above are discarded.
//  - When the slice with index NUM_SLICES-1 is accepted: index becomes 0, state becomes HOLD, and
//    out_valid=1 on the next cycle. Latency from the last slice accept to out_valid is 1 clk.
//  - out_data is stable while out_valid && !out_ready.
//  - HOLD with out_ready=1: out_valid drops next cycle. The exception is a simultaneous accept of
//    slice 0: that beat starts the next word, and state returns to COLLECT with index=1.
//  - Resync rule:
//    - in_first=1 accepted with index!=0: drop the partial word, store this beat as slice 0,
//      set index=1, and pulse err_resync next cycle.
//    - in_first=1 with index==0: normal.
//    - in_first=0 with index==0: accepted as slice 0, no error. in_first is advisory only.
//  - NUM_SLICES==1: every accepted beat completes a word. Valid throughput is 1 word/clk when
//    out_ready is held at 1.
//  - Index counter width is $clog2(NUM_SLICES) bits, with a minimum of 1. It wraps at NUM_SLICES-1
//    explicitly, not by overflow.
// STRUCTURE
//  - slice_pkg holds:
//    - function num_slices(width, max_w): start at 1; while ceil(width/n) > max_w, set n = n*2
//      and continue. Power-of-two result.
//    - function slice_width(width, n) = (width+n-1)/n.
//    - typedef enum logic {COLLECT, HOLD} reasm_state_e.
//  - One sub-module: slice_index_ctr. It provides the modulo-NUM_SLICES counter with clr, load1
//    (resync) and inc inputs, plus a last flag.
//  - The assembly register, output register and FSM stay in slice_reassembler.
// TESTING
//  1. Defaults; slices 9'h001,002,003,004 (first=1 on beat 0), out_ready=1 -> out_data=33'h0_200C_0401,
//     out_valid 1 clk after beat 3.
//  2. Last slice 9'h1FF, others 0 -> out_data=33'h1_F800_0000; bits 35:33 are dropped.
//  3. Hold out_ready=0 for 5 clk after a word -> in_ready=0 and out_data stable. Release out_ready
//     together with slice 0 of the next word -> both transfers happen in one clk.
//  4. Send 2 slices, then in_first=1 -> err_resync pulses once. The next 4 slices 9'h005..008
//     produce a word built from those slices only.
//  5. Assert rst after 3 slices of a word -> out_valid=0, index=0. The next 4 slices yield a clean word.
//  6. WIDTH=8, MAX_WIDTH=11 -> NUM_SLICES=1, SLICE_W=8. 4 back-to-back beats -> 4 words on
//     4 consecutive clks.

Source files
------------

// File: rtl/slice_pkg.sv
// Shared types and sizing helpers for the narrow-lane slicing scheme.
// Both ends of a link must derive slice count and width from these functions.
package slice_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } reasm_state_e;

  // Smallest power-of-two slice count whose slice width fits within max_w.
  function automatic int unsigned num_slices(input int unsigned width, input int unsigned max_w);
    int unsigned n;
    n = 1;
    while (((width + n - 1) / n) > max_w) n = n * 2;
    return n;
  endfunction

  function automatic int unsigned slice_width(input int unsigned width, input int unsigned n);
    return (width + n - 1) / n;
  endfunction

endpackage

// File: rtl/slice_reassembler_if.sv
// Slice-in / word-out valid-ready link for the reassembler.
// master drives beats and consumes words; slave is the reassembler.
interface slice_reassembler_if #(
  parameter int unsigned WIDTH   = 33,
  parameter int unsigned SLICE_W = 9
);
  logic               in_valid;
  logic               in_ready;
  logic               in_first;
  logic [SLICE_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               err_resync;

  modport master (
    output in_valid, in_first, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_resync
  );

  modport slave (
    input  in_valid, in_first, in_data, out_ready,
    output in_ready, out_valid, out_data, err_resync
  );
endinterface

// File: rtl/slice_index_ctr.sv
// Modulo-N slice index counter with clear, resync load-to-one and increment.
// Wraps explicitly at N-1 so non-power-of-two counts stay in range.
module slice_index_ctr #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'((N > 1) ? 1 : 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (load1) begin
      idx <= ONE_IDX;
    end else if (inc) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  assign last = (idx == LAST_IDX);

endmodule

// File: rtl/slice_reassembler.sv
// Rebuilds a WIDTH-bit word from NUM_SLICES narrow beats, LS slice first.
// A beat marked first mid-word drops the partial word and restarts assembly.
module slice_reassembler
  import slice_pkg::*;
#(
  parameter int unsigned WIDTH     = 33,
  parameter int unsigned MAX_WIDTH = 11
) (
  input logic                clk,
  input logic                rst,
  slice_reassembler_if.slave bus
);

  localparam int unsigned NUM_SLICES = num_slices(WIDTH, MAX_WIDTH);
  localparam int unsigned SLICE_W    = slice_width(WIDTH, NUM_SLICES);
  localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int unsigned ASM_W      = NUM_SLICES * SLICE_W;

  reasm_state_e       state_q, state_d;
  logic [ASM_W-1:0]   asm_q, asm_d;
  logic [WIDTH-1:0]   data_q;
  logic               valid_q;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx, slot;
  logic               last;
  logic               accept, resync, load_out;
  logic               ctr_clr, ctr_load1, ctr_inc;

  slice_index_ctr #(
    .N     (NUM_SLICES),
    .IDX_W (IDX_W)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .inc   (ctr_inc),
    .idx   (idx),
    .last  (last)
  );

  // Pass-through accept: a draining held word frees the slot in the same cycle.
  assign bus.in_ready   = (state_q == COLLECT) || (valid_q && bus.out_ready);
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.err_resync = err_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign resync = accept && bus.in_first && (idx != '0);
  assign slot   = resync ? '0 : idx;

  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    err_d     = 1'b0;
    load_out  = 1'b0;
    ctr_clr   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_inc   = 1'b0;

    if (accept) begin
      if (resync) begin
        asm_d     = '0;
        ctr_load1 = 1'b1;
        err_d     = 1'b1;
      end else if (last) begin
        ctr_clr  = 1'b1;
        load_out = 1'b1;
      end else begin
        ctr_inc = 1'b1;
      end
      for (int unsigned s = 0; s < NUM_SLICES; s++) begin
        if (slot == IDX_W'(s)) asm_d[s*SLICE_W +: SLICE_W] = bus.in_data;
      end
    end

    case (state_q)
      COLLECT: if (load_out) state_d = HOLD;
      HOLD:    if (bus.out_ready && !load_out) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Slice bits beyond WIDTH on the final beat are dropped at the output load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      valid_q <= (state_d == HOLD);
      err_q   <= err_d;
      if (load_out) data_q <= asm_d[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_slice_reassembler.sv
// Directed bench for slice_reassembler: default 4x9 slicing plus a
// single-slice (WIDTH=8) instance for the one-beat-per-word case.
module tb_slice_reassembler;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  slice_reassembler_if #(.WIDTH(33), .SLICE_W(9)) b0 ();
  slice_reassembler_if #(.WIDTH(8),  .SLICE_W(8)) b1 ();

  slice_reassembler #(.WIDTH(33), .MAX_WIDTH(11)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  slice_reassembler #(.WIDTH(8), .MAX_WIDTH(11)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [8:0] d, input logic f);
    b0.in_valid = 1'b1;
    b0.in_first = f;
    b0.in_data  = d;
  endtask

  task automatic idle0();
    b0.in_valid = 1'b0;
    b0.in_first = 1'b0;
    b0.in_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (b0.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b want 0", b0.out_valid);
    end
    vectors++;
    if (b0.out_data !== 33'h0) begin
      miscompares++; $display("FAIL reset_out_data: got %h want 0", b0.out_data);
    end
    vectors++;
    if (b0.err_resync !== 1'b0) begin
      miscompares++; $display("FAIL reset_err: got %b want 0", b0.err_resync);
    end
    vectors++;
    if (b0.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b want 1", b0.in_ready);
    end
    vectors++;
    if (b1.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid_w8: got %b want 0", b1.out_valid);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [8:0] beats [4] = '{9'h001, 9'h002, 9'h003, 9'h004};
    b0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive0(beats[i], i == 0);
      #1;
      vectors++;
      if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_collect beat %0d: in_ready %b out_valid %b want 1/0", i, b0.in_ready, b0.out_valid);
      end
      tick();
    end
    idle0();
    #1;
    vectors++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 33'h0_200C_0401) begin
      miscompares++;
      $display("FAIL basic_word: valid %b data %h want 1 %h", b0.out_valid, b0.out_data, 33'h0_200C_0401);
    end
    tick();
    vectors++;
    if (b0.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_drain: out_valid %b want 0", b0.out_valid);
    end
  endtask

  task automatic test_drop_high();
    logic [8:0] beats [4] = '{9'h000, 9'h000, 9'h000, 9'h1FF};
    b0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive0(beats[i], i == 0);
      tick();
    end
    idle0();
    #1;
    vectors++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 33'h1_F800_0000) begin
      miscompares++;
      $display("FAIL drop_high: valid %b data %h want 1 %h", b0.out_valid, b0.out_data, 33'h1_F800_0000);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [8:0] beats [4] = '{9'h011, 9'h022, 9'h033, 9'h044};
    logic [8:0] tail  [3] = '{9'h0BB, 9'h0CC, 9'h0DD};
    b0.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive0(beats[i], i == 0);
      tick();
    end
    drive0(9'h0AA, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b1 || b0.out_data !== 33'h0_20CC_4411) begin
        miscompares++;
        $display("FAIL hold cycle %0d: in_ready %b valid %b data %h want 0 1 %h",
                 k, b0.in_ready, b0.out_valid, b0.out_data, 33'h0_20CC_4411);
      end
      tick();
    end
    b0.out_ready = 1'b1;
    #1;
    vectors++;
    if (b0.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL passthrough_ready: got %b want 1", b0.in_ready);
    end
    tick();
    vectors++;
    if (b0.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL passthrough_drain: out_valid %b want 0", b0.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive0(tail[i], 1'b0);
      #1;
      vectors++;
      if (b0.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL tail_ready beat %0d: got %b want 1", i, b0.in_ready);
      end
      tick();
    end
    idle0();
    #1;
    vectors++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 33'h0_EB31_76AA) begin
      miscompares++;
      $display("FAIL passthrough_word: valid %b data %h want 1 %h", b0.out_valid, b0.out_data, 33'h0_EB31_76AA);
    end
    tick();
  endtask

  task automatic test_resync();
    b0.out_ready = 1'b1;
    drive0(9'h0F0, 1'b1);
    tick();
    drive0(9'h0F1, 1'b0);
    tick();
    vectors++;
    if (b0.err_resync !== 1'b0) begin
      miscompares++; $display("FAIL resync_quiet: err %b want 0", b0.err_resync);
    end
    drive0(9'h005, 1'b1);
    tick();
    vectors++;
    if (b0.err_resync !== 1'b1) begin
      miscompares++; $display("FAIL resync_pulse: err %b want 1", b0.err_resync);
    end
    drive0(9'h006, 1'b0);
    tick();
    vectors++;
    if (b0.err_resync !== 1'b0) begin
      miscompares++; $display("FAIL resync_one_cycle: err %b want 0", b0.err_resync);
    end
    drive0(9'h007, 1'b0);
    tick();
    drive0(9'h008, 1'b0);
    tick();
    idle0();
    #1;
    vectors++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 33'h0_401C_0C05) begin
      miscompares++;
      $display("FAIL resync_word: valid %b data %h want 1 %h", b0.out_valid, b0.out_data, 33'h0_401C_0C05);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [8:0] part  [3] = '{9'h0E1, 9'h0E2, 9'h0E3};
    logic [8:0] beats [4] = '{9'h101, 9'h102, 9'h103, 9'h104};
    b0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive0(part[i], i == 0);
      tick();
    end
    idle0();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (b0.out_valid !== 1'b0 || b0.out_data !== 33'h0 || b0.err_resync !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: valid %b data %h err %b want 0 0 0", b0.out_valid, b0.out_data, b0.err_resync);
    end
    for (int i = 0; i < 4; i++) begin
      drive0(beats[i], 1'b0);
      tick();
    end
    idle0();
    #1;
    vectors++;
    if (b0.out_valid !== 1'b1 || b0.out_data !== 33'h0_240E_0501 || b0.err_resync !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_word: valid %b data %h err %b want 1 %h 0",
               b0.out_valid, b0.out_data, b0.err_resync, 33'h0_240E_0501);
    end
    tick();
  endtask

  task automatic test_single_slice();
    logic [7:0] beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    b1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b1.in_valid = 1'b1;
      b1.in_first = 1'b1;
      b1.in_data  = beats[i];
      #1;
      vectors++;
      if (b1.in_ready !== 1'b1) begin
        miscompares++; $display("FAIL w8_ready beat %0d: got %b want 1", i, b1.in_ready);
      end
      tick();
      vectors++;
      if (b1.out_valid !== 1'b1 || b1.out_data !== beats[i]) begin
        miscompares++;
        $display("FAIL w8_word %0d: valid %b data %h want 1 %h", i, b1.out_valid, b1.out_data, beats[i]);
      end
    end
    b1.in_valid = 1'b0;
    b1.in_first = 1'b0;
    tick();
    vectors++;
    if (b1.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL w8_drain: out_valid %b want 0", b1.out_valid);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    idle0();
    b0.out_ready = 1'b0;
    b1.in_valid  = 1'b0;
    b1.in_first  = 1'b0;
    b1.in_data   = '0;
    b1.out_ready = 1'b0;

    test_reset();
    test_basic();
    test_drop_high();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_single_slice();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
